// File: rtl/cache_pkg.sv
// Definitions shared by the 4-way set-associative cache and its main-memory responder.
package cache_pkg;

    localparam int unsigned WORD_SIZE       = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK;
    localparam int unsigned ADDR_WIDTH      = 29;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BLOCK_SIZE-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_block_array.sv
// Block storage with one synchronous write port and one registered read port; no reset,
// so contents and the read register are undefined until written.
module mem_block_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency block memory responder: serves one refill read or dirty writeback at a time,
// returning a one-cycle resp_valid pulse LATENCY cycles after acceptance.
module main_memory_responder #(
    parameter int unsigned WORD_SIZE       = cache_pkg::WORD_SIZE,
    parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int unsigned BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
    parameter int unsigned ADDR_WIDTH      = cache_pkg::ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned LATENCY         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BLOCK_SIZE-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [BLOCK_SIZE-1:0] resp_rdata
);

    import cache_pkg::*;

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t            r_state, w_state_next;
    logic [CntW-1:0]       r_cnt, w_cnt_next;
    logic                  r_ready;
    logic                  r_write;
    logic [IdxW-1:0]       r_idx;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic                  r_resp_read;
    logic                  w_accept;
    logic                  w_is_write;
    logic                  w_re;
    logic                  w_we;
    logic [IdxW-1:0]       w_raddr;
    logic [BLOCK_SIZE-1:0] w_arr_rdata;
    logic                  w_unused_addr;

    // Upper address bits alias silently onto the array.
    assign w_unused_addr = ^req_addr[ADDR_WIDTH-1:IdxW];

    assign w_accept = (r_state == IDLE) && r_ready && req_valid;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = BUSY;
                        w_cnt_next   = CntW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CntW'(1)) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The array read is launched on the edge entering RESP so the data lands in the RESP
    // cycle; with LATENCY==1 that edge is the accept edge, hence the bypass of the capture.
    assign w_is_write = (r_state == IDLE) ? req_write : r_write;
    assign w_raddr    = (r_state == IDLE) ? req_addr[IdxW-1:0] : r_idx;
    assign w_re       = (w_state_next == RESP) && !w_is_write;
    assign w_we       = (r_state == RESP) && r_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_resp_read <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ready <= (w_state_next == IDLE);
            if (w_accept) begin
                r_write <= req_write;
                r_idx   <= req_addr[IdxW-1:0];
                r_wdata <= req_wdata;
            end
            if (w_state_next == RESP) begin
                r_resp_read <= !w_is_write;
            end
        end
    end

    mem_block_array #(
        .DEPTH(MEM_DEPTH),
        .WIDTH(BLOCK_SIZE),
        .AW   (IdxW)
    ) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_idx),
        .i_wdata(r_wdata),
        .i_re   (w_re),
        .i_raddr(w_raddr),
        .o_rdata(w_arr_rdata)
    );

    assign req_ready  = r_ready;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_resp_read ? w_arr_rdata : '0;

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Block-granular main-memory responder on the memory side of the 4-way set-associative cache. It accepts one refill-read or dirty-writeback request at a time and serves it after a programmable fixed latency. Refills return a whole block; writebacks are acknowledged. It sits between the cache controller FSM and the backing storage, and doubles as the memory model in cache-level benches.

## Interface
- WORD_SIZE, 32, bits per word
- WORDS_PER_BLOCK, 4, words per cache block
- BLOCK_SIZE, WORD_SIZE*WORDS_PER_BLOCK, bits per block (128)
- ADDR_WIDTH, 29, block address width (cache TAG_WIDTH 25 + INDEX_WIDTH 4)
- MEM_DEPTH, 1024, blocks of storage; power of two
- LATENCY, 4, cycles from request acceptance to response; must be ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; fixed as asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  0 = refill read, 1 = dirty writeback
- req_addr  in  ADDR_WIDTH  block address {tag, index}
- req_wdata  in  BLOCK_SIZE  writeback block (the cache's dirty_block_out)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  BLOCK_SIZE  refill block (the cache's data_in_mem)

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. If req_valid is high at a rising edge, the request is accepted. req_write, req_addr and req_wdata are captured into internal registers. The latency counter loads LATENCY-1, and the state goes to BUSY, or to RESP directly if LATENCY==1.
- BUSY: req_ready=0. The counter decrements each cycle. At 0 the state goes to RESP.
- RESP: resp_valid=1 for exactly this cycle, req_ready=0, then return to IDLE.
  - Read: resp_rdata = array[addr] for the captured address.
  - Write: the captured block is committed to the array on the edge leaving RESP. resp_rdata = 0.
- Array index = req_addr[$clog2(MEM_DEPTH)-1:0]. Upper address bits are ignored, so out-of-range addresses alias silently.
- resp_rdata is registered and holds its value until the next RESP cycle.
- Input changes after acceptance have no effect, because the captured copy is used.
- req_valid in BUSY/RESP is ignored. The requester must hold it until it sees req_ready.
- Array contents are not cleared by reset and are X after power-up.

## Timing
- Reset values while rst_n=0: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, counter 0.
- req_ready is registered. It rises on the first rising edge after rst_n deasserts.
- Acceptance at edge E gives resp_valid high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after acceptance. req_ready is high again in the following cycle.
- Back-to-back throughput is one request per LATENCY+1 cycles.
- A read issued immediately after a write to the same address returns the new data. Requests are serialized and the write commits before IDLE.
- Reset asserted mid-operation aborts immediately. No pending write is committed and no resp_valid is produced.
- Simultaneous req_valid with RESP is not accepted. The request is taken in the next IDLE cycle.

## Structure
- Shared package cache_pkg holds:
  - WORD_SIZE, WORDS_PER_BLOCK, BLOCK_SIZE and ADDR_WIDTH defaults;
  - enum mem_state_t {IDLE, BUSY, RESP};
  - packed struct mem_req_t {write, addr, wdata}.
  The cache and this block share these definitions.
- One sub-module, mem_block_array: a synchronous MEM_DEPTH×BLOCK_SIZE storage with one write port and one read port, with no reset. The responder holds the FSM, counter and capture registers.

## Test plan
- Reset then idle: rst_n low for 3 cycles → req_ready=0, resp_valid=0, resp_rdata=0. req_ready=1 one edge after release.
- Write then read, LATENCY=4: write addr 0x00000A1 with data 0x11112222_33334444_55556666_77778888 → resp_valid pulse 4 cycles after acceptance, resp_rdata=0. Then read 0x00000A1 → resp_rdata equals the written block, 4 cycles after acceptance.
- Aliasing: write 0x0000005 with block A, then read 0x0000405 (MEM_DEPTH=1024) → returns A.
- Held inputs and busy: change req_addr/req_wdata and keep req_valid high during BUSY → response uses the original values, exactly one resp_valid, next acceptance only after RESP.
- Reset mid-write: accept write to 0x0000003 with block B (array previously held C), pull rst_n low in BUSY → no resp_valid. A later read of 0x0000003 returns C.
- LATENCY=1 build: a read request is accepted → resp_valid appears in the very next cycle. Back-to-back reads are accepted every 2 cycles.
